// File: rtl/mystic_wb_pipe.sv
// Writeback delay pipeline: carries register-file writes through DEPTH
// stages, commits them from the oldest stage and forwards pending results
// to operand lookups. Youngest matching stage wins a forwarding race.
module mystic_wb_pipe #(
    parameter int DEPTH  = 3,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic              in_we_i,
    input  logic [ADDR_W-1:0] in_rd_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    output logic              out_we_o,
    output logic [ADDR_W-1:0] out_rd_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_commit_o,
    input  logic [ADDR_W-1:0] rs1_i,
    input  logic [ADDR_W-1:0] rs2_i,
    output logic              fwd1_hit_o,
    output logic              fwd2_hit_o,
    output logic [DATA_W-1:0] fwd1_data_o,
    output logic [DATA_W-1:0] fwd2_data_o,
    output logic [3:0]        occupancy_o
);

    // Stage storage, index 0 is the youngest entry.
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] we_q;
    logic [ADDR_W-1:0] rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    // True when stage k holds a live write that can satisfy lookup index rs.
    function automatic logic stage_match(input logic v, input logic w,
                                         input logic [ADDR_W-1:0] rd,
                                         input logic [ADDR_W-1:0] rs);
        return v && w && (rd == rs) && (rs != '0);
    endfunction

    // Shift register: reset clears everything, flush kills valids only,
    // stall freezes the whole pipe and ignores the input entry.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            vld_q <= '0;
            we_q  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rd_q[k]   <= '0;
                data_q[k] <= '0;
            end
        end else if (flush_i) begin
            vld_q <= '0;
        end else if (!stall_i) begin
            vld_q[0]  <= in_valid_i;
            we_q[0]   <= in_we_i;
            rd_q[0]   <= in_rd_i;
            data_q[0] <= in_data_i;
            for (int k = 1; k < DEPTH; k++) begin
                vld_q[k]  <= vld_q[k-1];
                we_q[k]   <= we_q[k-1];
                rd_q[k]   <= rd_q[k-1];
                data_q[k] <= data_q[k-1];
            end
        end
    end

    assign out_valid_o = vld_q[DEPTH-1];
    assign out_we_o    = we_q[DEPTH-1];
    assign out_rd_o    = rd_q[DEPTH-1];
    assign out_data_o  = data_q[DEPTH-1];

    // A held entry only strobes once, on the cycle the stall releases.
    assign out_commit_o = out_valid_o & out_we_o & (out_rd_o != '0) & ~stall_i & ~flush_i;

    // Forwarding scan from oldest to youngest so the youngest match overrides.
    always_comb begin
        fwd1_hit_o  = 1'b0;
        fwd1_data_o = '0;
        fwd2_hit_o  = 1'b0;
        fwd2_data_o = '0;
        for (int k = DEPTH-1; k >= 0; k--) begin
            if (stage_match(vld_q[k], we_q[k], rd_q[k], rs1_i)) begin
                fwd1_hit_o  = 1'b1;
                fwd1_data_o = data_q[k];
            end
            if (stage_match(vld_q[k], we_q[k], rd_q[k], rs2_i)) begin
                fwd2_hit_o  = 1'b1;
                fwd2_data_o = data_q[k];
            end
        end
    end

    // Population count of live stages.
    always_comb begin
        occupancy_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy_o = occupancy_o + {3'b000, vld_q[k]};
        end
    end

endmodule

// File: tb/tb_mystic_wb_pipe.sv
// Directed bench for mystic_wb_pipe at DEPTH=3: a cycle table for the
// streaming/forwarding behaviour plus hand sequences for stall, flush, reset.
module tb_mystic_wb_pipe;

    logic        clk_i = 1'b0;
    logic        rstn_i, stall_i, flush_i;
    logic        in_valid_i, in_we_i;
    logic [4:0]  in_rd_i, rs1_i, rs2_i;
    logic [63:0] in_data_i;
    logic        out_valid_o, out_we_o, out_commit_o;
    logic [4:0]  out_rd_o;
    logic [63:0] out_data_o, fwd1_data_o, fwd2_data_o;
    logic        fwd1_hit_o, fwd2_hit_o;
    logic [3:0]  occupancy_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    mystic_wb_pipe #(.DEPTH(3), .DATA_W(64), .ADDR_W(5)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .stall_i(stall_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_we_i(in_we_i), .in_rd_i(in_rd_i), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_we_o(out_we_o), .out_rd_o(out_rd_o),
        .out_data_o(out_data_o), .out_commit_o(out_commit_o),
        .rs1_i(rs1_i), .rs2_i(rs2_i),
        .fwd1_hit_o(fwd1_hit_o), .fwd2_hit_o(fwd2_hit_o),
        .fwd1_data_o(fwd1_data_o), .fwd2_data_o(fwd2_data_o),
        .occupancy_o(occupancy_o)
    );

    typedef struct packed {
        logic        v;
        logic        we;
        logic [4:0]  rd;
        logic [63:0] dat;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_ov;
        logic        e_cm;
        logic [4:0]  e_rd;
        logic [63:0] e_dat;
        logic        e_h1;
        logic [63:0] e_d1;
        logic        e_h2;
        logic [63:0] e_d2;
        logic [3:0]  e_occ;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge; outputs are then
    // sampled 1 time unit later, well before the next rising edge.
    task automatic step(input logic rn, input logic st, input logic fl,
                        input logic v, input logic we, input logic [4:0] rd,
                        input logic [63:0] dat);
        @(negedge clk_i);
        rstn_i = rn; stall_i = st; flush_i = fl;
        in_valid_i = v; in_we_i = we; in_rd_i = rd; in_data_i = dat;
        #1;
    endtask

    initial begin
        vt[0] = '{1'b1, 1'b1, 5'd5, 64'hAA, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h0,  4'd0};
        vt[1] = '{1'b1, 1'b1, 5'd7, 64'h1,  5'd5, 5'd7, 1'b0, 1'b0, 5'd0, 64'h0,  1'b1, 64'hAA, 1'b0, 64'h0,  4'd1};
        vt[2] = '{1'b1, 1'b1, 5'd7, 64'h2,  5'd7, 5'd5, 1'b0, 1'b0, 5'd0, 64'h0,  1'b1, 64'h1,  1'b1, 64'hAA, 4'd2};
        vt[3] = '{1'b0, 1'b1, 5'd7, 64'h33, 5'd7, 5'd5, 1'b1, 1'b1, 5'd5, 64'hAA, 1'b1, 64'h2,  1'b1, 64'hAA, 4'd3};
        vt[4] = '{1'b1, 1'b1, 5'd0, 64'hFF, 5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 64'h1,  1'b1, 64'h2,  1'b0, 64'h0,  4'd2};
        vt[5] = '{1'b0, 1'b0, 5'd0, 64'h0,  5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 64'h2,  1'b1, 64'h2,  1'b0, 64'h0,  4'd2};
        vt[6] = '{1'b0, 1'b0, 5'd0, 64'h0,  5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 64'h33, 1'b0, 64'h0,  1'b0, 64'h0,  4'd1};
        vt[7] = '{1'b0, 1'b0, 5'd0, 64'h0,  5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 64'hFF, 1'b0, 64'h0,  1'b0, 64'h0,  4'd1};
        vt[8] = '{1'b0, 1'b0, 5'd0, 64'h0,  5'd7, 5'd0, 1'b0, 1'b0, 5'd0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h0,  4'd0};

        rstn_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        in_valid_i = 1'b0; in_we_i = 1'b0; in_rd_i = '0; in_data_i = '0;
        rs1_i = '0; rs2_i = '0;

        // Reset with stall and flush also high: reset must still win.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 64'h99);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        rs1_i = 5'd9; rs2_i = 5'd9;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        chk("rst_valid",  64'(out_valid_o),  64'd0);
        chk("rst_commit", 64'(out_commit_o), 64'd0);
        chk("rst_occ",    64'(occupancy_o),  64'd0);
        chk("rst_h1",     64'(fwd1_hit_o),   64'd0);
        chk("rst_d1",     fwd1_data_o,       64'd0);
        chk("rst_d2",     fwd2_data_o,       64'd0);
        chk("rst_data",   out_data_o,        64'd0);

        // Streaming, youngest-wins forwarding, bubble and rd=0 behaviour.
        for (int i = 0; i < 9; i++) begin
            rs1_i = vt[i].rs1; rs2_i = vt[i].rs2;
            step(1'b1, 1'b0, 1'b0, vt[i].v, vt[i].we, vt[i].rd, vt[i].dat);
            chk($sformatf("t%0d_ov", i),  64'(out_valid_o),  64'(vt[i].e_ov));
            chk($sformatf("t%0d_cm", i),  64'(out_commit_o), 64'(vt[i].e_cm));
            chk($sformatf("t%0d_rd", i),  64'(out_rd_o),     64'(vt[i].e_rd));
            chk($sformatf("t%0d_dat", i), out_data_o,        vt[i].e_dat);
            chk($sformatf("t%0d_h1", i),  64'(fwd1_hit_o),   64'(vt[i].e_h1));
            chk($sformatf("t%0d_d1", i),  fwd1_data_o,       vt[i].e_d1);
            chk($sformatf("t%0d_h2", i),  64'(fwd2_hit_o),   64'(vt[i].e_h2));
            chk($sformatf("t%0d_d2", i),  fwd2_data_o,       vt[i].e_d2);
            chk($sformatf("t%0d_occ", i), 64'(occupancy_o),  64'(vt[i].e_occ));
        end

        // Stall holding an entry in the output stage.
        rs1_i = 5'd0; rs2_i = 5'd0;
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 64'h3C);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 64'h9);
            chk($sformatf("stall%0d_ov", i),  64'(out_valid_o),  64'd1);
            chk($sformatf("stall%0d_cm", i),  64'(out_commit_o), 64'd0);
            chk($sformatf("stall%0d_rd", i),  64'(out_rd_o),     64'd3);
            chk($sformatf("stall%0d_dat", i), out_data_o,        64'h3C);
            chk($sformatf("stall%0d_occ", i), 64'(occupancy_o),  64'd1);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        chk("unstall_cm", 64'(out_commit_o), 64'd1);
        chk("unstall_rd", 64'(out_rd_o),     64'd3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        chk("post_stall_cm",  64'(out_commit_o), 64'd0);
        chk("post_stall_occ", 64'(occupancy_o),  64'd0);

        // Flush with stall high drops three in-flight entries.
        rs1_i = 5'd10; rs2_i = 5'd12;
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 64'h10);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd11, 64'h11);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd12, 64'h12);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd13, 64'h13);
        chk("fl_pre_occ", 64'(occupancy_o),  64'd3);
        chk("fl_pre_cm",  64'(out_commit_o), 64'd0);
        chk("fl_pre_h2",  fwd2_data_o,       64'h12);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd14, 64'h14);
        chk("fl_occ", 64'(occupancy_o),  64'd0);
        chk("fl_cm",  64'(out_commit_o), 64'd0);
        chk("fl_ov",  64'(out_valid_o),  64'd0);
        chk("fl_h1",  64'(fwd1_hit_o),   64'd0);
        chk("fl_h2",  64'(fwd2_hit_o),   64'd0);
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
            chk($sformatf("fl_new%0d_cm", i), 64'(out_commit_o), (i == 3) ? 64'd1 : 64'd0);
        end
        chk("fl_new_rd",  64'(out_rd_o), 64'd14);
        chk("fl_new_dat", out_data_o,    64'h14);

        // Reset mid-stream discards everything in flight.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        rs1_i = 5'd21; rs2_i = 5'd20;
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd20, 64'h20);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd21, 64'h21);
        chk("mr_pre_h1", 64'(fwd1_hit_o), 64'd0);
        chk("mr_pre_h2", 64'(fwd2_hit_o), 64'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd22, 64'h22);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
        chk("mr_ov",  64'(out_valid_o),  64'd0);
        chk("mr_occ", 64'(occupancy_o),  64'd0);
        chk("mr_h1",  64'(fwd1_hit_o),   64'd0);
        chk("mr_h2",  64'(fwd2_hit_o),   64'd0);
        chk("mr_rd",  64'(out_rd_o),     64'd0);
        chk("mr_dat", out_data_o,        64'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0);
            chk($sformatf("mr_after%0d_cm", i), 64'(out_commit_o), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
